// File: rtl/coherence_bus_ctrl.sv
// Snoopy MSI bus controller: arbitrates two dcaches and two icaches onto one RAM port,
// snoops the non-requesting dcache and forwards dirty blocks. Optional macro: CC_FWD_EN.
module coherence_bus_ctrl #(
  parameter int unsigned CPUS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CPUS-1:0]           dren_i,
  input  logic [CPUS-1:0]           dwen_i,
  input  logic [CPUS-1:0]           cctrans_i,
  input  logic [CPUS-1:0]           ccwrite_i,
  input  logic [CPUS-1:0][31:0]     daddr_i,
  input  logic [CPUS-1:0][31:0]     dstore_i,
  output logic [CPUS-1:0]           dwait_o,
  output logic [CPUS-1:0][31:0]     dload_o,
  output logic [CPUS-1:0]           ccwait_o,
  output logic [CPUS-1:0]           ccinv_o,
  output logic [CPUS-1:0][31:0]     ccsnoopaddr_o,
  input  logic [CPUS-1:0]           iren_i,
  input  logic [CPUS-1:0][31:0]     iaddr_i,
  output logic [CPUS-1:0]           iwait_o,
  output logic [CPUS-1:0][31:0]     iload_o,
  output logic                      ramren_o,
  output logic                      ramwen_o,
  output logic [31:0]               ramaddr_o,
  output logic [31:0]               ramstore_o,
  input  logic [31:0]               ramload_i,
  input  logic [1:0]                ramstate_i
);

  localparam int unsigned AW  = 32;
  localparam int unsigned OFF = 3;
  localparam logic [1:0]  RS_ACCESS = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_IFETCH, S_WB, S_INV, S_SNOOP, S_DECIDE, S_FWD0, S_FWD1, S_MEM0, S_MEM1
  } state_e;

  state_e          state_q, state_d;
  logic            r_q, r_d;
  logic            dlast_q, dlast_d;
  logic            ilast_q, ilast_d;

  logic [CPUS-1:0] dreq;
  logic            dgnt, ignt, s, access, fwd_ind;
  logic [AW-1:0]   snp_blk;

  // Grant the non-last requester on a tie, otherwise whichever one asks.
  assign dreq    = dren_i | dwen_i | cctrans_i;
  assign dgnt    = (&dreq)   ? ~dlast_q : dreq[1];
  assign ignt    = (&iren_i) ? ~ilast_q : iren_i[1];
  assign s       = ~r_q;
  assign access  = (ramstate_i == RS_ACCESS);
  assign fwd_ind = cctrans_i[s] & ~dren_i[s] & ~dwen_i[s] & ~ccwrite_i[s];
  assign snp_blk = {daddr_i[r_q][AW-1:OFF], OFF'(0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= 1'b0;
      dlast_q <= 1'b1;
      ilast_q <= 1'b1;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      dlast_q <= dlast_d;
      ilast_q <= ilast_d;
    end
  end

  // Next state and all bus outputs; outputs are idle unless the state drives them.
  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    dlast_d       = dlast_q;
    ilast_d       = ilast_q;
    dwait_o       = '1;
    dload_o       = '0;
    ccwait_o      = '0;
    ccinv_o       = '0;
    ccsnoopaddr_o = '0;
    iwait_o       = '1;
    iload_o       = '0;
    ramren_o      = 1'b0;
    ramwen_o      = 1'b0;
    ramaddr_o     = '0;
    ramstore_o    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (|dreq) begin
          r_d     = dgnt;
          dlast_d = dgnt;
          if (dwen_i[dgnt])                           state_d = S_WB;
          else if (cctrans_i[dgnt] && !dren_i[dgnt])  state_d = S_INV;
          else                                        state_d = S_SNOOP;
        end else if (|iren_i) begin
          r_d     = ignt;
          ilast_d = ignt;
          state_d = S_IFETCH;
        end
      end

      S_IFETCH: begin
        ramren_o      = 1'b1;
        ramaddr_o     = iaddr_i[r_q];
        iload_o[r_q]  = ramload_i;
        if (access) begin
          iwait_o[r_q] = 1'b0;
          state_d      = S_IDLE;
        end
      end

      S_WB: begin
        ramwen_o   = 1'b1;
        ramaddr_o  = daddr_i[r_q];
        ramstore_o = dstore_i[r_q];
        if (access) begin
          dwait_o[r_q] = 1'b0;
          state_d      = S_IDLE;
        end
      end

      S_INV: begin
        ccwait_o[s]      = 1'b1;
        ccinv_o[s]       = 1'b1;
        ccsnoopaddr_o[s] = daddr_i[r_q];
        dwait_o[r_q]     = 1'b0;
        state_d          = S_IDLE;
      end

      S_SNOOP, S_DECIDE: begin
        ccwait_o[s]      = 1'b1;
        ccinv_o[s]       = ccwrite_i[r_q];
        ccsnoopaddr_o[s] = snp_blk;
        if (state_q == S_SNOOP) state_d = S_DECIDE;
        else                    state_d = fwd_ind ? S_FWD0 : S_MEM0;
      end

      // Snooper's dirty word goes to RAM; with forwarding the requester takes it too.
      S_FWD0, S_FWD1: begin
        ccwait_o[s]      = 1'b1;
        ccinv_o[s]       = ccwrite_i[r_q];
        ccsnoopaddr_o[s] = snp_blk;
        ramwen_o         = 1'b1;
        ramaddr_o        = daddr_i[s];
        ramstore_o       = dstore_i[s];
`ifdef CC_FWD_EN
        dload_o[r_q]     = dstore_i[s];
        if (access) begin
          dwait_o[s]   = 1'b0;
          dwait_o[r_q] = 1'b0;
          state_d      = (state_q == S_FWD0) ? S_FWD1 : S_IDLE;
        end
`else
        if (access) begin
          dwait_o[s] = 1'b0;
          state_d    = (state_q == S_FWD0) ? S_FWD1 : S_MEM0;
        end
`endif
      end

      S_MEM0, S_MEM1: begin
        ccwait_o[s]      = 1'b1;
        ccsnoopaddr_o[s] = snp_blk;
        ramren_o         = 1'b1;
        ramaddr_o        = daddr_i[r_q];
        dload_o[r_q]     = ramload_i;
        if (access) begin
          dwait_o[r_q] = 1'b0;
          state_d      = (state_q == S_MEM0) ? S_MEM1 : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/coherence_bus_ctrl.md
# coherence_bus_ctrl

Snoopy MSI bus controller and memory arbiter for the dual-core design. It is the responder side of the cache coherence interface used by both dcaches and icaches. It serialises their requests onto a single RAM port. It issues snoops (`ccwait`, `ccinv`, `ccsnoopaddr`) to the non-requesting dcache and routes forwarded dirty blocks back to the requester.

## Interface
- CPUS, default 2: number of cores. Fixed at 2; index `i` below is 0..1.
- CLK  in  1  system clock.
- nRST  in  1  reset, asynchronous, active-low.
- dREN[i], dWEN[i], cctrans[i], ccwrite[i]  in  1 each  dcache request and coherence flags.
- daddr[i], dstore[i]  in  32 each  dcache word address and store data.
- dwait[i]  out  1  dcache stall; low for exactly one cycle per completed word or transaction.
- dload[i]  out  32  dcache load data.
- ccwait[i], ccinv[i]  out  1 each  snoop hold and invalidate to dcache i.
- ccsnoopaddr[i]  out  32  snoop address to dcache i.
- iREN[i]  in  1  icache read request.
- iaddr[i]  in  32  icache word address.
- iwait[i]  out  1  icache stall.
- iload[i]  out  32  icache load data.
- ramREN, ramWEN  out  1 each  RAM read and write strobes.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM state: FREE=0, BUSY=1, ACCESS=2, ERROR=3. A word completes when ramstate==ACCESS.

## Operation
- **dcache request:** dcache i requests when `dREN[i]|dWEN[i]|cctrans[i]`. Any dcache request beats any icache request.
- **dcache arbitration:** round-robin register `last`. If both dcaches request, grant the one ≠ `last`. `last` updates to the grantee when the grant is taken in IDLE.
- **icache arbitration:** separate round-robin, same rule, used only when no dcache is requesting.
- **Snooper:** `s = ~r`, where `r` is the granted requester.
- **Forward indicator:** `cctrans[s] & ~dREN[s] & ~dWEN[s] & ~ccwrite[s]`.
- **States:** IDLE, IFETCH, WB, INV, SNOOP, DECIDE, FWD0, FWD1, MEM0, MEM1.
- **IDLE:** choose the path from the granted request:
  - dWEN → WB.
  - cctrans & ~dREN & ~dWEN (upgrade) → INV.
  - dREN → SNOOP.
  - icache only → IFETCH.
- **IFETCH:** ramREN=1, ramaddr=iaddr, iload=ramload. iwait low on ACCESS, then → IDLE.
- **WB (writeback/flush word):** ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r]. dwait[r] low on ACCESS, then → IDLE. No snoop.
- **INV:** ccwait[s]=1, ccinv[s]=1, ccsnoopaddr[s]=daddr[r], dwait[r]=0 for one cycle, then → IDLE.
- **SNOOP (1 cycle):** ccwait[s]=1, ccinv[s]=ccwrite[r], ccsnoopaddr[s]={daddr[r][31:3],3'b0}. Always → DECIDE.
- **DECIDE (1 cycle):** hold the SNOOP outputs. If the forward indicator is set → FWD0, else → MEM0.
- **FWD0 / FWD1 (snooper owns block in M):**
  - Hold ccwait[s]=1 and ccinv[s].
  - ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s].
  - dload[r]=dstore[s].
  - On ACCESS, dwait[s] and dwait[r] go low together for one cycle. FWD0 → FWD1, FWD1 → IDLE.
- **MEM0 / MEM1:** ccwait[s] held. ramREN=1, ramaddr=daddr[r], dload[r]=ramload. dwait[r] low on ACCESS. MEM0 → MEM1, MEM1 → IDLE.
- **ramstate ERROR:** treated as BUSY (stall), never a completion.
- **Non-granted outputs:** every non-granted cache sees dwait/iwait=1 and dload/iload=0.

## Timing
- **Reset values:**
  - dwait, iwait = all 1.
  - ccwait, ccinv, ccsnoopaddr, dload, iload = 0.
  - ramREN, ramWEN, ramaddr, ramstore = 0.
  - State=IDLE; both round-robin registers = 1 (core 0 wins the first tie).
- **Reset mid-transaction:** returns to IDLE immediately; all outputs take their reset values asynchronously.
- **Outputs:** all outputs are combinational from state and inputs; state is registered.
- **Latencies with a RAM that gives ACCESS on the first cycle:**
  - Plain miss: IDLE + SNOOP + DECIDE + 2 words = 5 cycles.
  - Forwarded miss: 5 cycles.
  - INV: 2 cycles.
  - WB word: 2 cycles.
- **Snoop window:** ccwait[s] rises in SNOOP and stays high through the last word of the transaction. It falls in the cycle after the final dwait pulse.
- **Request persistence:** requests are level signals held until dwait falls. A request dropped mid-transaction is not supported.

## Configuration
- CC_FWD_EN defined: cache-to-cache forwarding as described in FWD0/FWD1 (requester receives the snooper data directly).
- CC_FWD_EN undefined:
  - FWD0/FWD1 write the snooper data to RAM only; dwait[r] stays high.
  - After FWD1, go to MEM0 and the requester reads the refreshed block from RAM.
  - Adds 2 RAM word latencies.

## Test plan
- **Plain miss:** core0 dREN, cctrans, daddr=0x100; core1 has no copy; RAM returns 0xAAAA0000 then 0xAAAA0004 → ramREN at 0x100 then 0x104; dload[0] shows each word with a 1-cycle dwait[0] pulse; ccwait[1]=1 and ccinv[1]=0 throughout.
- **Forwarded miss:** core1 holds 0x200 in M (data 0x11, 0x22); core0 reads with ccwrite=1 → ccinv[1]=1; ramWEN to 0x200 and 0x204; dload[0]=0x11 then 0x22; no ramREN with CC_FWD_EN.
- **Upgrade:** core1 upgrade (cctrans, ccwrite, daddr=0x300) → ccinv[0]=1, ccsnoopaddr[0]=0x300, dwait[1] low in the 2nd cycle.
- **Tie arbitration:** both dcaches write after reset → core0 served first, then core1; icache iREN held throughout is served only after both.
- **Stall and reset:** ramstate held at ERROR for 5 cycles → no dwait pulse; assert nRST during MEM1 → all outputs return to reset values the same cycle.
